dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the multicycle core's memory port and main memory.
//  Core side: single-request handshake; the core FSM stalls until o_done is asserted.
//  Memory side: valid/ready request channel plus an rvalid read-return channel, with burst refill of one line.
// PARAMETERS
//  ADDR_WIDTH   64  byte address width
//  DATA_WIDTH   64  word width; byte strobes are DATA_WIDTH/8 bits wide
//  SETS         16  number of lines; power of 2, >= 2
//  BLOCK_WORDS  4   words per line; power of 2, >= 2
// PORTS
//  clk            in   1           clock; all state updates on the rising edge
//  arst           in   1           reset, asynchronous, active-high
//  i_req_valid    in   1           core request present
//  i_req_write    in   1           1 = store, 0 = load
//  i_addr         in   ADDR_WIDTH  byte address; bits [2:0] are ignored (word-aligned)
//  i_wdata        in   DATA_WIDTH  store data
//  i_wstrb        in   DATA_WIDTH/8  store byte enables
//  i_flush        in   1           invalidate all lines
//  o_req_ready    out  1           high only in IDLE
//  o_done         out  1           1-cycle pulse when the request completes
//  o_rdata        out  DATA_WIDTH  load data; valid while o_done = 1
//  o_mem_valid    out  1           memory request valid
//  i_mem_ready    in   1           memory accepts the request
//  o_mem_write    out  1           1 = single-beat write, 0 = BLOCK_WORDS-beat read burst
//  o_mem_addr     out  ADDR_WIDTH  request address (line-aligned for reads)
//  o_mem_wdata    out  DATA_WIDTH  write data
//  o_mem_wstrb    out  DATA_WIDTH/8  write byte enables
//  i_mem_rvalid   in   1           read beat valid; beats arrive in order, word 0 first
//  i_mem_rdata    in   DATA_WIDTH  read beat data
// BEHAVIOUR
//  Address split: offset [2:0]; word = next log2(BLOCK_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
//  Reset (arst high): state IDLE, all valid bits 0, word counter 0.
//    All outputs 0 except o_req_ready = 1. Data and tag arrays are not reset.
//  Request acceptance: a request is accepted when i_req_valid && o_req_ready.
//    Address, data, strobes and type are registered. i_req_valid while busy is ignored.
//  States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WRITE_REQ, RESP.
//  IDLE:
//    i_flush = 1: clear all valid bits this cycle and stay in IDLE. Flush takes priority over a request in the same cycle.
//    Request accepted (no flush): -> LOOKUP.
//  LOOKUP: hit = valid[index] && tag match.
//    Read hit:   o_done = 1, o_rdata = line word -> IDLE. Latency: o_done 1 cycle after acceptance.
//    Read miss:  -> REFILL_REQ.
//    Write, any: on a hit, merge the strobed bytes into the line this cycle -> WRITE_REQ.
//  REFILL_REQ:
//    Drive o_mem_valid = 1, o_mem_write = 0, o_mem_addr = line base. Hold until i_mem_ready, then -> REFILL_WAIT.
//    Clear valid[index] on acceptance.
//  REFILL_WAIT:
//    Each i_mem_rvalid writes beat[cnt] and increments cnt.
//    On the last beat (cnt = BLOCK_WORDS-1): set the tag, set valid[index], reset cnt to 0, -> RESP.
//  RESP: o_done = 1, o_rdata = requested word from the filled line -> IDLE. Read-miss latency = 3 + handshake wait + beat count.
//  WRITE_REQ:
//    Drive o_mem_valid = 1, o_mem_write = 1, o_mem_addr = word address, plus registered wdata/wstrb.
//    On i_mem_ready: o_done = 1 the same cycle -> IDLE. No allocate on a write miss.
//  o_mem_* fields stay stable while o_mem_valid = 1 and i_mem_ready = 0.
//  i_mem_rvalid outside REFILL_WAIT is ignored.
//  arst during a refill: line stays invalid, cnt = 0, no o_done.
//    Memory beats still in flight after reset are ignored: they arrive in IDLE, where rvalid has no effect.
// STRUCTURE
//  dcache_pkg: state enum t_dcache_state; localparams OFFSET_W, WORD_W, INDEX_W, TAG_W derived from the parameters.
//  Sub-module dcache_array: tag, data and valid storage.
//    Combinational read; synchronous byte-masked write; one-cycle clear-all for flush.
//  dcache_ctrl contains the FSM, request registers, beat counter and output muxing.
// TESTING (SETS=16, BLOCK_WORDS=4)
//  1. Reset, then load 0x1008 -> one read burst at 0x1000 with beats A0..A3.
//     o_done with o_rdata = A1. Repeat load 0x1008 -> o_done 1 cycle after acceptance, no o_mem_valid.
//  2. Store 0x1010 with wdata 0xFF, wstrb 0x01, after the line is cached.
//     -> write beat at 0x1010 with wstrb 0x01. Then load 0x1010 hits, and the low byte reads 0xFF.
//  3. Store to uncached 0x2000 -> one write beat, o_done.
//     Then load 0x2000 -> read burst (no allocate on the store).
//  4. Hold i_mem_ready = 0 for 5 cycles during REFILL_REQ.
//     -> o_mem_addr stable, o_mem_valid held, and i_req_valid is ignored throughout.
//  5. Assert arst after beat 2 of a refill. Load the same address.
//     -> new full burst; stray beats arriving in IDLE do not change state.
//  6. i_flush and i_req_valid together in IDLE -> request not accepted.
//     The next load of a previously cached address misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned ADDR_WIDTH  = 64;
  localparam int unsigned DATA_WIDTH  = 64;
  localparam int unsigned SETS        = 16;
  localparam int unsigned BLOCK_WORDS = 4;

  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned OFFSET_W   = $clog2(STRB_W);
  localparam int unsigned WORD_W     = $clog2(BLOCK_WORDS);
  localparam int unsigned INDEX_W    = $clog2(SETS);
  localparam int unsigned TAG_W      = ADDR_WIDTH - OFFSET_W - WORD_W - INDEX_W;
  localparam int unsigned WADDR_W    = ADDR_WIDTH - OFFSET_W;
  localparam int unsigned LINE_OFF_W = WORD_W + OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_WRITE_REQ,
    S_RESP
  } t_dcache_state;

  // Registered core request; the byte offset is dropped since accesses are word-aligned.
  typedef struct packed {
    logic                  write;
    logic [WADDR_W-1:0]    waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
  } t_core_req;

endpackage

// File: rtl/dcache_array.sv
// Tag, data and valid storage: combinational read, byte-masked synchronous write, flush clear.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_clear_all,
  input  logic                  i_inv,
  input  logic                  i_tag_we,
  input  logic                  i_data_we,
  input  logic [INDEX_W-1:0]    i_index,
  input  logic [WORD_W-1:0]     i_rword,
  input  logic [WORD_W-1:0]     i_wword,
  input  logic [TAG_W-1:0]      i_wtag,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_W-1:0]     i_wstrb,
  output logic [TAG_W-1:0]      o_tag_c,
  output logic                  o_valid_c,
  output logic [DATA_WIDTH-1:0] o_rdata_c
);

  logic [SETS-1:0]       r_valid;
  logic [TAG_W-1:0]      r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS][BLOCK_WORDS];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_valid <= '0;
    end else if (i_clear_all) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_index] <= 1'b1;
    end else if (i_inv) begin
      r_valid[i_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_tag_we) begin
      r_tag[i_index] <= i_wtag;
    end
  end

  always_ff @(posedge clk) begin
    if (i_data_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_data[i_index][i_wword][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_tag_c   = r_tag[i_index];
  assign o_valid_c = r_valid[i_index];
  assign o_rdata_c = r_data[i_index][i_rword];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with line refill.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_W-1:0]     i_wstrb,
  input  logic                  i_flush,
  output logic                  o_req_ready,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [STRB_W-1:0]     o_mem_wstrb,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  t_dcache_state         r_state, w_next;
  t_core_req             r_req;
  logic [WORD_W-1:0]     r_cnt;

  logic                  w_accept, w_hit;
  logic                  w_clear_all, w_inv, w_tag_we, w_data_we;
  logic [WORD_W-1:0]     w_wword;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [TAG_W-1:0]      w_rd_tag;
  logic                  w_rd_valid;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [INDEX_W-1:0]    w_index;
  logic [WORD_W-1:0]     w_word;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_unused_offset;

  assign w_word          = r_req.waddr[WORD_W-1:0];
  assign w_index         = r_req.waddr[WORD_W +: INDEX_W];
  assign w_tag           = r_req.waddr[WADDR_W-1 -: TAG_W];
  assign w_hit           = w_rd_valid && (w_rd_tag == w_tag);
  assign w_unused_offset = ^i_addr[OFFSET_W-1:0];

  dcache_array u_array (
    .clk         (clk),
    .arst        (arst),
    .i_clear_all (w_clear_all),
    .i_inv       (w_inv),
    .i_tag_we    (w_tag_we),
    .i_data_we   (w_data_we),
    .i_index     (w_index),
    .i_rword     (w_word),
    .i_wword     (w_wword),
    .i_wtag      (w_tag),
    .i_wdata     (w_wdata),
    .i_wstrb     (w_wstrb),
    .o_tag_c     (w_rd_tag),
    .o_valid_c   (w_rd_valid),
    .o_rdata_c   (w_rd_data)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req <= '{write: i_req_write, waddr: i_addr[ADDR_WIDTH-1:OFFSET_W],
                 wdata: i_wdata, wstrb: i_wstrb};
    end
  end

  // Beat counter wraps to 0 naturally after the last beat of a line.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (r_state == S_REFILL_WAIT && i_mem_rvalid) begin
      r_cnt <= r_cnt + WORD_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_clear_all = 1'b0;
    w_inv       = 1'b0;
    w_tag_we    = 1'b0;
    w_data_we   = 1'b0;
    w_wword     = w_word;
    w_wdata     = r_req.wdata;
    w_wstrb     = r_req.wstrb;
    o_req_ready = 1'b0;
    o_done      = 1'b0;
    o_rdata     = '0;
    o_mem_valid = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wstrb = '0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_flush) begin
          w_clear_all = 1'b1;
        end else if (i_req_valid) begin
          w_accept = 1'b1;
          w_next   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (r_req.write) begin
          w_data_we = w_hit;
          w_next    = S_WRITE_REQ;
        end else if (w_hit) begin
          o_done  = 1'b1;
          o_rdata = w_rd_data;
          w_next  = S_IDLE;
        end else begin
          w_next = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {w_tag, w_index, LINE_OFF_W'(0)};
        if (i_mem_ready) begin
          w_inv  = 1'b1;
          w_next = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        if (i_mem_rvalid) begin
          w_data_we = 1'b1;
          w_wword   = r_cnt;
          w_wdata   = i_mem_rdata;
          w_wstrb   = '1;
          if (r_cnt == WORD_W'(BLOCK_WORDS - 1)) begin
            w_tag_we = 1'b1;
            w_next   = S_RESP;
          end
        end
      end
      S_RESP: begin
        o_done  = 1'b1;
        o_rdata = w_rd_data;
        w_next  = S_IDLE;
      end
      S_WRITE_REQ: begin
        o_mem_valid = 1'b1;
        o_mem_write = 1'b1;
        o_mem_addr  = {r_req.waddr, OFFSET_W'(0)};
        o_mem_wdata = r_req.wdata;
        o_mem_wstrb = r_req.wstrb;
        if (i_mem_ready) begin
          o_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: behavioural memory responder plus core-side request tasks.
module tb_dcache_ctrl;

  localparam int unsigned BW = 4;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_write = 1'b0;
  logic [63:0] i_addr = '0;
  logic [63:0] i_wdata = '0;
  logic [7:0]  i_wstrb = '0;
  logic        i_flush = 1'b0;
  logic        o_req_ready, o_done, o_mem_valid, o_mem_write;
  logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [63:0] i_mem_rdata = '0;

  dcache_ctrl dut (
    .clk          (clk),
    .arst         (arst),
    .i_req_valid  (i_req_valid),
    .i_req_write  (i_req_write),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_wstrb      (i_wstrb),
    .i_flush      (i_flush),
    .o_req_ready  (o_req_ready),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_write  (o_mem_write),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wstrb  (o_mem_wstrb),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit chk; logic [63:0] data; } t_exp_done;
  typedef struct { bit wr; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wstrb; } t_exp_mem;

  t_exp_done   exp_done_q[$];
  t_exp_mem    exp_mem_q[$];
  logic [63:0] mem_m [logic [63:0]];

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [63:0] last_rdata = '0;
  int          stall_left = 0;
  int          beats_left = 0;
  int          beat_idx = 0;
  logic [63:0] beat_base = '0;
  bit          last_wr = 1'b0;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    logic [63:0] wa;
    wa = a & ~64'h7;
    if (mem_m.exists(wa)) return mem_m[wa];
    return {~wa[31:0], wa[31:0]};
  endfunction

  // Completion scoreboard: every o_done pulse must match the oldest expected completion.
  always @(negedge clk) begin : mon_done
    t_exp_done e;
    #2;
    if (o_done === 1'b1) begin
      done_cnt++;
      last_rdata = o_rdata;
      n_checks++;
      if (exp_done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: o_done=1 rdata=%h, required no completion", o_rdata);
      end else begin
        e = exp_done_q.pop_front();
        if (e.chk && o_rdata !== e.data) begin
          n_fail++;
          $display("FAIL done_rdata: got %h, required %h", o_rdata, e.data);
        end
      end
    end
  end

  // Memory responder: accepts requests after an optional stall, returns bursts, applies writes.
  always @(negedge clk) begin : mem_rsp
    t_exp_mem    e;
    logic [63:0] w;
    if (i_mem_ready) begin
      i_mem_ready = 1'b0;
      if (!last_wr) begin
        beats_left = BW;
        beat_idx   = 0;
      end
    end
    if (beats_left > 0) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = mem_rd(beat_base + 64'(beat_idx * 8));
      beat_idx++;
      beats_left--;
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
    end
    if (!i_mem_ready && o_mem_valid === 1'b1) begin
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        i_mem_ready = 1'b1;
        last_wr     = o_mem_write;
        n_checks++;
        if (exp_mem_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_unexpected: write=%0b addr=%h, required no memory request", o_mem_write, o_mem_addr);
        end else begin
          e = exp_mem_q.pop_front();
          if (o_mem_write !== e.wr || o_mem_addr !== e.addr ||
              (e.wr && (o_mem_wdata !== e.wdata || o_mem_wstrb !== e.wstrb))) begin
            n_fail++;
            $display("FAIL mem_req: got wr=%0b addr=%h wdata=%h wstrb=%h, required wr=%0b addr=%h wdata=%h wstrb=%h",
                     o_mem_write, o_mem_addr, o_mem_wdata, o_mem_wstrb, e.wr, e.addr, e.wdata, e.wstrb);
          end
        end
        if (o_mem_write) begin
          w = mem_rd(o_mem_addr);
          for (int b = 0; b < 8; b++) if (o_mem_wstrb[b]) w[b*8 +: 8] = o_mem_wdata[b*8 +: 8];
          mem_m[o_mem_addr & ~64'h7] = w;
        end else begin
          beat_base = o_mem_addr;
        end
      end
    end
  end

  task automatic do_req(input string name, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        input bit exp_fill, input int exp_lat, input bit hold);
    t_exp_done   ed;
    t_exp_mem    em;
    int          d0, lat;
    bit          seen;
    logic [63:0] a0;
    ed.chk  = !wr;
    ed.data = wr ? 64'h0 : mem_rd(addr);
    exp_done_q.push_back(ed);
    if (wr) begin
      em = '{1'b1, addr & ~64'h7, wdata, wstrb};
      exp_mem_q.push_back(em);
    end else if (exp_fill) begin
      em = '{1'b0, addr & ~64'(BW * 8 - 1), 64'h0, 8'h0};
      exp_mem_q.push_back(em);
    end
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_addr      = addr;
    i_wdata     = wdata;
    i_wstrb     = wstrb;
    d0          = done_cnt;
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: o_req_ready=%b, required 1", name, o_req_ready);
    end
    @(negedge clk);
    i_req_valid = hold;
    if (hold) begin
      i_addr      = addr ^ 64'h4000;
      i_req_write = ~wr;
    end
    lat  = 0;
    seen = 1'b0;
    a0   = '0;
    for (int k = 1; k <= 200; k++) begin
      #3;
      if (done_cnt != d0) begin
        lat = k;
        break;
      end
      if (o_mem_valid === 1'b1) begin
        n_checks++;
        if (o_req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_busy_ready: o_req_ready=%b, required 0", name, o_req_ready);
        end
        if (!seen) begin
          a0   = o_mem_addr;
          seen = 1'b1;
        end else begin
          n_checks++;
          if (o_mem_addr !== a0) begin
            n_fail++;
            $display("FAIL %s_addr_stable: o_mem_addr=%h, required %h", name, o_mem_addr, a0);
          end
        end
      end
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    n_checks++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: no o_done within 200 cycles, required completion", name);
      exp_done_q.delete();
    end else if (exp_lat >= 0 && lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (exp_mem_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_mem_missing: %0d expected memory requests not seen, required 0", name, exp_mem_q.size());
      exp_mem_q.delete();
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    #3;
    n_checks++;
    if (o_req_ready !== 1'b1 || o_done !== 1'b0 || o_mem_valid !== 1'b0 || o_mem_write !== 1'b0 ||
        o_mem_addr !== 64'h0 || o_rdata !== 64'h0 || o_mem_wstrb !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b done=%b mvalid=%b mwrite=%b maddr=%h rdata=%h, required ready=1 rest 0",
               o_req_ready, o_done, o_mem_valid, o_mem_write, o_mem_addr, o_rdata);
    end
  endtask

  task automatic test_load_miss_hit();
    do_req("load_miss", 1'b0, 64'h1008, 64'h0, 8'h0, 1'b1, 7, 1'b0);
    do_req("load_hit",  1'b0, 64'h1008, 64'h0, 8'h0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_store_hit();
    do_req("store_hit", 1'b1, 64'h1010, 64'hFF, 8'h01, 1'b0, 2, 1'b0);
    do_req("load_after_store", 1'b0, 64'h1010, 64'h0, 8'h0, 1'b0, 1, 1'b0);
    n_checks++;
    if (last_rdata[7:0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL store_low_byte: got %h, required ff", last_rdata[7:0]);
    end
  endtask

  task automatic test_store_miss();
    do_req("store_miss", 1'b1, 64'h2000, 64'h1122_3344_5566_7788, 8'hF0, 1'b0, 2, 1'b0);
    do_req("load_no_alloc", 1'b0, 64'h2000, 64'h0, 8'h0, 1'b1, 7, 1'b0);
  endtask

  task automatic test_refill_stall();
    stall_left = 5;
    do_req("stall_load", 1'b0, 64'h1058, 64'h0, 8'h0, 1'b1, 12, 1'b1);
  endtask

  task automatic test_reset_mid_refill();
    t_exp_mem em;
    int       d0;
    bit       hit2;
    em = '{1'b0, 64'h3040, 64'h0, 8'h0};
    exp_mem_q.push_back(em);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_addr      = 64'h3048;
    @(negedge clk);
    i_req_valid = 1'b0;
    d0   = done_cnt;
    hit2 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #3;
      if (beat_idx == 2 && beats_left == 2) begin
        hit2 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!hit2) begin
      n_fail++;
      $display("FAIL rst_refill_beats: beat_idx=%0d, required 2 within 50 cycles", beat_idx);
    end
    #4;
    arst = 1'b1;
    @(negedge clk);
    #1;
    arst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #3;
      n_checks++;
      if (o_req_ready !== 1'b1 || o_mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_refill_idle: ready=%b mvalid=%b, required 1 and 0", o_req_ready, o_mem_valid);
      end
    end
    n_checks++;
    if (done_cnt != d0 || exp_mem_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_refill_done: done pulses=%0d pending mem=%0d, required 0 and 0",
               done_cnt - d0, exp_mem_q.size());
      exp_mem_q.delete();
    end
    do_req("rst_reload", 1'b0, 64'h3048, 64'h0, 8'h0, 1'b1, 7, 1'b0);
  endtask

  task automatic test_flush();
    int d0;
    do_req("flush_pre_hit", 1'b0, 64'h3048, 64'h0, 8'h0, 1'b0, 1, 1'b0);
    @(negedge clk);
    i_flush     = 1'b1;
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_addr      = 64'h3048;
    d0          = done_cnt;
    @(negedge clk);
    i_flush     = 1'b0;
    i_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      n_checks++;
      if (o_req_ready !== 1'b1 || o_mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_not_accepted: ready=%b mvalid=%b, required 1 and 0", o_req_ready, o_mem_valid);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL flush_no_done: %0d completions, required 0", done_cnt - d0);
    end
    do_req("flush_miss", 1'b0, 64'h3048, 64'h0, 8'h0, 1'b1, 7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_miss_hit();
    test_store_hit();
    test_store_miss();
    test_refill_stall();
    test_reset_mid_refill();
    test_flush();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
